// File: rtl/vip_axi4s_types_pkg.sv
// rtl/vip_axi4s_types_pkg.sv - shared AXI4-Stream types for the packet arbiter
package vip_axi4s_types_pkg;

  typedef enum logic {
    IDLE_E   = 1'b0,
    LOCKED_E = 1'b1
  } axi4s_arb_state_t;

  typedef struct packed {
    logic [15:0] nr_of_masters;
    logic [15:0] tdata_width;
    logic [15:0] tid_width;
    logic [15:0] tdest_width;
    logic [15:0] tuser_width;
  } axi4s_arb_cfg_t;

  // Index width that stays at least one bit so N=1 still has a legal port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - round-robin request picker, searching upward from last+1
module rr_priority_encoder
  import vip_axi4s_types_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   last,
  output logic [idx_width(N)-1:0]   gnt_id,
  output logic                      gnt_vld
);

  localparam int LW = idx_width(N);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over the window (last, last+N].
  always_comb begin
    req2    = {req, req};
    mask    = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      mask[i] = (i > int'(last)) && (i <= int'(last) + N);
    end
    masked = req2 & mask;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = LW'(i % N);
      end
    end
  end

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// rtl/axi4s_rr_arbiter.sv - packet-level round-robin AXI4-Stream arbiter
module axi4s_rr_arbiter
  import vip_axi4s_types_pkg::*;
#(
  parameter int NR_OF_MASTERS_P = 4,
  parameter int TDATA_WIDTH_P   = 32,
  parameter int TID_WIDTH_P     = 2,
  parameter int TDEST_WIDTH_P   = 2,
  parameter int TUSER_WIDTH_P   = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NR_OF_MASTERS_P-1:0]                  mst_tvalid,
  output logic [NR_OF_MASTERS_P-1:0]                  mst_tready,
  input  logic [NR_OF_MASTERS_P*TDATA_WIDTH_P-1:0]    mst_tdata,
  input  logic [NR_OF_MASTERS_P*TDATA_WIDTH_P/8-1:0]  mst_tstrb,
  input  logic [NR_OF_MASTERS_P*TDATA_WIDTH_P/8-1:0]  mst_tkeep,
  input  logic [NR_OF_MASTERS_P-1:0]                  mst_tlast,
  input  logic [NR_OF_MASTERS_P*TID_WIDTH_P-1:0]      mst_tid,
  input  logic [NR_OF_MASTERS_P*TDEST_WIDTH_P-1:0]    mst_tdest,
  input  logic [NR_OF_MASTERS_P*TUSER_WIDTH_P-1:0]    mst_tuser,
  output logic                                        slv_tvalid,
  input  logic                                        slv_tready,
  output logic [TDATA_WIDTH_P-1:0]                    slv_tdata,
  output logic [TDATA_WIDTH_P/8-1:0]                  slv_tstrb,
  output logic [TDATA_WIDTH_P/8-1:0]                  slv_tkeep,
  output logic                                        slv_tlast,
  output logic [TID_WIDTH_P-1:0]                      slv_tid,
  output logic [TDEST_WIDTH_P-1:0]                    slv_tdest,
  output logic [TUSER_WIDTH_P-1:0]                    slv_tuser,
  output logic [idx_width(NR_OF_MASTERS_P)-1:0]       grant_id,
  output logic                                        busy
);

  localparam int N  = NR_OF_MASTERS_P;
  localparam int D  = TDATA_WIDTH_P;
  localparam int S  = TDATA_WIDTH_P / 8;
  localparam int I  = TID_WIDTH_P;
  localparam int T  = TDEST_WIDTH_P;
  localparam int U  = TUSER_WIDTH_P;
  localparam int LW = idx_width(N);

  axi4s_arb_state_t state, state_nxt;
  logic [LW-1:0]    last_grant;
  logic [LW-1:0]    enc_id;
  logic             enc_vld;
  logic             pkt_done;

  rr_priority_encoder #(.N(N)) u_enc (
    .req     (mst_tvalid),
    .last    (last_grant),
    .gnt_id  (enc_id),
    .gnt_vld (enc_vld)
  );

  assign pkt_done = slv_tvalid & slv_tready & slv_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE_E;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_E:   if (enc_vld)  state_nxt = LOCKED_E;
      LOCKED_E: if (pkt_done) state_nxt = IDLE_E;
      default:  state_nxt = IDLE_E;
    endcase
  end

  // last_grant starts at N-1 so the first search begins at input 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= LW'(N - 1);
    end else if (state == IDLE_E && enc_vld) begin
      grant_id   <= enc_id;
    end else if (pkt_done) begin
      last_grant <= grant_id;
    end
  end

  always_comb begin
    busy       = (state == LOCKED_E);
    slv_tvalid = 1'b0;
    slv_tdata  = '0;
    slv_tstrb  = '0;
    slv_tkeep  = '0;
    slv_tlast  = 1'b0;
    slv_tid    = '0;
    slv_tdest  = '0;
    slv_tuser  = '0;
    mst_tready = '0;
    if (state == LOCKED_E) begin
      for (int i = 0; i < N; i++) begin
        if (LW'(i) == grant_id) begin
          slv_tvalid    = mst_tvalid[i];
          slv_tdata     = mst_tdata[i*D +: D];
          slv_tstrb     = mst_tstrb[i*S +: S];
          slv_tkeep     = mst_tkeep[i*S +: S];
          slv_tlast     = mst_tlast[i];
          slv_tid       = mst_tid[i*I +: I];
          slv_tdest     = mst_tdest[i*T +: T];
          slv_tuser     = mst_tuser[i*U +: U];
          mst_tready[i] = slv_tready;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// tb/tb_axi4s_rr_arbiter.sv - randomized and directed bench for axi4s_rr_arbiter
module tb_axi4s_rr_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  dest;
    logic        user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mst_tvalid = '0;
  logic [3:0]  mst_tready;
  logic [127:0] mst_tdata = '0;
  logic [15:0] mst_tstrb = '0;
  logic [15:0] mst_tkeep = '0;
  logic [3:0]  mst_tlast = '0;
  logic [7:0]  mst_tid = '0;
  logic [7:0]  mst_tdest = '0;
  logic [3:0]  mst_tuser = '0;
  logic        slv_tvalid;
  logic        slv_tready = 1'b0;
  logic [31:0] slv_tdata;
  logic [3:0]  slv_tstrb;
  logic [3:0]  slv_tkeep;
  logic        slv_tlast;
  logic [1:0]  slv_tid;
  logic [1:0]  slv_tdest;
  logic [0:0]  slv_tuser;
  logic [1:0]  grant_id;
  logic        busy;

  axi4s_rr_arbiter #(
    .NR_OF_MASTERS_P(4), .TDATA_WIDTH_P(32), .TID_WIDTH_P(2),
    .TDEST_WIDTH_P(2), .TUSER_WIDTH_P(1)
  ) dut (
    .clk(clk), .rst(rst),
    .mst_tvalid(mst_tvalid), .mst_tready(mst_tready), .mst_tdata(mst_tdata),
    .mst_tstrb(mst_tstrb), .mst_tkeep(mst_tkeep), .mst_tlast(mst_tlast),
    .mst_tid(mst_tid), .mst_tdest(mst_tdest), .mst_tuser(mst_tuser),
    .slv_tvalid(slv_tvalid), .slv_tready(slv_tready), .slv_tdata(slv_tdata),
    .slv_tstrb(slv_tstrb), .slv_tkeep(slv_tkeep), .slv_tlast(slv_tlast),
    .slv_tid(slv_tid), .slv_tdest(slv_tdest), .slv_tuser(slv_tuser),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t q[4][$];
  bit    hold[4];
  int    vld_pct = 100;
  int    rdy_pct = 100;
  bit    m_locked;
  int    m_owner;
  int    m_last;
  int    grant_log[$];
  logic [31:0] vld_pattern;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = 3;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      hold[i] = 1'b0;
    end
    grant_log.delete();
    mst_tvalid = '0;
  endtask

  task automatic push_pkt(input int m, input int len, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = base + 32'(k);
      b.strb = 4'($urandom);
      b.keep = 4'($urandom);
      b.last = (k == len - 1);
      b.dest = 2'($urandom);
      b.user = 1'($urandom);
      q[m].push_back(b);
    end
  endtask

  // One clock cycle: drive sources, compare outputs against the model, advance model.
  task automatic step();
    beat_t      b;
    logic [3:0] exp_rdy;
    logic       exp_v;
    bit         done;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mst_tvalid[i] = (q[i].size() > 0) && (hold[i] || ($urandom_range(99) < vld_pct));
      hold[i] = mst_tvalid[i];
      b = (q[i].size() > 0) ? q[i][0] : '0;
      mst_tdata[i*32 +: 32] = b.data;
      mst_tstrb[i*4 +: 4]   = b.strb;
      mst_tkeep[i*4 +: 4]   = b.keep;
      mst_tlast[i]          = b.last;
      mst_tid[i*2 +: 2]     = 2'(i);
      mst_tdest[i*2 +: 2]   = b.dest;
      mst_tuser[i]          = b.user;
    end
    slv_tready = ($urandom_range(99) < rdy_pct);
    #1;
    exp_rdy = '0;
    exp_v   = 1'b0;
    done    = 1'b0;
    if (m_locked) begin
      exp_v = mst_tvalid[m_owner];
      exp_rdy[m_owner] = slv_tready;
    end
    check("busy", 32'(busy), 32'(m_locked));
    check("grant_id", 32'(grant_id), 32'(m_owner));
    check("slv_tvalid", 32'(slv_tvalid), 32'(exp_v));
    check("mst_tready", 32'(mst_tready), 32'(exp_rdy));
    vld_pattern = {vld_pattern[30:0], slv_tvalid};
    if (exp_v) begin
      b = q[m_owner][0];
      check("slv_tdata", slv_tdata, b.data);
      check("slv_tid", 32'(slv_tid), 32'(m_owner));
      check("slv_side", {19'd0, slv_tstrb, slv_tkeep, slv_tlast, slv_tdest, slv_tuser},
            {19'd0, b.strb, b.keep, b.last, b.dest, b.user});
      done = slv_tready && b.last;
    end
    for (int i = 0; i < 4; i++) begin
      if (mst_tvalid[i] && exp_rdy[i]) begin
        void'(q[i].pop_front());
        hold[i] = 1'b0;
      end
    end
    if (m_locked) begin
      if (done) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (mst_tvalid[(m_last + k) % 4]) begin
          m_locked = 1'b1;
          m_owner  = (m_last + k) % 4;
          grant_log.push_back(m_owner);
          break;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_locked) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check(tag, 32'(n), 32'(0));
  endtask

  task automatic check_grants(input string tag, input int exp[$]);
    check({tag, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      check(tag, 32'(grant_log[i]), 32'(exp[i]));
    grant_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slv_tvalid"}, 32'(slv_tvalid), 32'd0);
    check({tag, "_mst_tready"}, 32'(mst_tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_slv_tdata"}, slv_tdata, 32'd0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // All four inputs request; input 0 carries a second packet to show wrap-around.
    push_pkt(0, 2, 32'h1000_0000);
    push_pkt(0, 2, 32'h1000_0100);
    push_pkt(1, 2, 32'h1100_0000);
    push_pkt(2, 2, 32'h1200_0000);
    push_pkt(3, 2, 32'h1300_0000);
    vld_pct = 100;
    rdy_pct = 100;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("first_grant", {29'd0, busy, grant_id}, 32'h4);
    drain("drain_a", 100);
    check_grants("order_a", '{0, 1, 2, 3, 0});

    // Lone requester with single-beat packets: one bubble before every beat.
    push_pkt(2, 1, 32'h2000_0001);
    push_pkt(2, 1, 32'h2000_0002);
    push_pkt(2, 1, 32'h2000_0003);
    vld_pattern = '0;
    repeat (6) step();
    check("pattern_b", {26'd0, vld_pattern[5:0]}, 32'h15);
    drain("drain_b", 20);
    check_grants("order_b", '{2, 2, 2});

    // Output stall on input 1 while inputs 0 and 3 wait.
    push_pkt(1, 4, 32'hA5A5_0001);
    step();
    push_pkt(0, 2, 32'h3000_0000);
    push_pkt(3, 2, 32'h3300_0000);
    rdy_pct = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_tdata", slv_tdata, 32'hA5A5_0001);
      check("stall_ready", 32'(mst_tready), 32'd0);
    end
    rdy_pct = 100;
    drain("drain_c", 100);
    check_grants("order_c", '{1, 3, 0});

    // Random traffic with source gaps and output backpressure.
    vld_pct = 60;
    rdy_pct = 70;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 30) begin
        int m = $urandom_range(3);
        if (q[m].size() < 8) push_pkt(m, $urandom_range(1, 4), $urandom);
      end
      step();
    end
    vld_pct = 100;
    rdy_pct = 100;
    drain("drain_rand", 400);
    grant_log.delete();

    // Reset while beat 2 of a 4-beat packet is on the output.
    push_pkt(0, 4, 32'h4000_0000);
    step();
    step();
    step();
    check("pre_rst_beat2", slv_tdata, 32'h4000_0001);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    push_pkt(3, 1, 32'h5300_0000);
    push_pkt(1, 1, 32'h5100_0000);
    push_pkt(0, 1, 32'h5000_0000);
    push_pkt(2, 1, 32'h5200_0000);
    rst = 1'b0;
    drain("drain_e", 50);
    check_grants("order_e", '{0, 1, 2, 3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
